// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: command and error codes,
// ASCII symbols, argument limits and FSM state encodings.
package uart_cmd_pkg;

    localparam logic [3:0] CMD_NONE  = 4'd0;
    localparam logic [3:0] CMD_RUN   = 4'd1;
    localparam logic [3:0] CMD_STOP  = 4'd2;
    localparam logic [3:0] CMD_CLEAR = 4'd3;
    localparam logic [3:0] CMD_MODE  = 4'd4;
    localparam logic [3:0] CMD_DISP  = 4'd5;
    localparam logic [3:0] CMD_SEC   = 4'd6;
    localparam logic [3:0] CMD_MIN   = 4'd7;
    localparam logic [3:0] CMD_HOUR  = 4'd8;

    localparam logic [1:0] ERR_UNKNOWN = 2'd0;
    localparam logic [1:0] ERR_SYNTAX  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_RUN  = 8'h52; // R
    localparam logic [7:0] CH_STOP = 8'h53; // S
    localparam logic [7:0] CH_CLR  = 8'h43; // C
    localparam logic [7:0] CH_MODE = 8'h4D; // M
    localparam logic [7:0] CH_DISP = 8'h44; // D
    localparam logic [7:0] CH_SEC  = 8'h73; // s
    localparam logic [7:0] CH_MIN  = 8'h6D; // m
    localparam logic [7:0] CH_HOUR = 8'h68; // h

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OPCODE = 3'd1;
    localparam logic [2:0] ST_ARG    = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/cmd_char_decode.sv
// Combinational byte classifier: opcode letter (with command code and
// whether it accepts an argument), decimal digit, or line terminator.
module cmd_char_decode
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] byte_in,
    output logic              is_opcode,
    output logic [3:0]        code,
    output logic              takes_arg,
    output logic              is_digit,
    output logic [3:0]        digit,
    output logic              is_term
);

    always_comb begin
        is_opcode = 1'b1;
        takes_arg = 1'b0;
        code      = CMD_NONE;
        case (byte_in)
            DATA_W'(CH_RUN):  code = CMD_RUN;
            DATA_W'(CH_STOP): code = CMD_STOP;
            DATA_W'(CH_CLR):  code = CMD_CLEAR;
            DATA_W'(CH_MODE): code = CMD_MODE;
            DATA_W'(CH_DISP): code = CMD_DISP;
            DATA_W'(CH_SEC):  begin code = CMD_SEC;  takes_arg = 1'b1; end
            DATA_W'(CH_MIN):  begin code = CMD_MIN;  takes_arg = 1'b1; end
            DATA_W'(CH_HOUR): begin code = CMD_HOUR; takes_arg = 1'b1; end
            default:          is_opcode = 1'b0;
        endcase
    end

    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the value.
    assign is_digit = (byte_in >= DATA_W'(CH_0)) && (byte_in <= DATA_W'(CH_9));
    assign digit    = byte_in[3:0];
    assign is_term  = (byte_in == DATA_W'(CH_CR)) || (byte_in == DATA_W'(CH_LF));

endmodule

// File: rtl/uart_cmd_parser.sv
// Multi-byte ASCII command parser draining a show-ahead UART RX FIFO.
// Ports: clk/rst, FIFO head (i_rx_data/i_rx_empty/o_rx_pop), i_line_mode,
// command strobe (o_cmd_valid/o_cmd_code/o_arg/o_arg_valid),
// error strobe (o_err/o_err_code) and o_busy while a line is open.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ARG_DIGITS  = 2,
    parameter int ARG_W       = 7,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_empty,
    output logic              o_rx_pop,
    input  logic              i_line_mode,
    output logic              o_cmd_valid,
    output logic [3:0]        o_cmd_code,
    output logic [ARG_W-1:0]  o_arg,
    output logic              o_arg_valid,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(ARG_DIGITS + 1);
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    if (pow10(ARG_DIGITS) - 1 >= (1 << ARG_W)) begin : g_arg_w_check
        $error("ARG_W cannot hold ARG_DIGITS decimal digits");
    end

    logic [2:0]       state;
    logic [3:0]       op_code;
    logic             op_arg;
    logic [ARG_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pend;
    logic [TMO_W-1:0] tmo_cnt;

    logic       d_opcode;
    logic [3:0] d_code;
    logic       d_takes;
    logic       d_digit;
    logic [3:0] d_val;
    logic       d_term;
    logic       can_pop;
    logic       tmo_hit;
    logic       in_range;

    cmd_char_decode #(.DATA_W(DATA_W)) u_dec (
        .byte_in   (i_rx_data),
        .is_opcode (d_opcode),
        .code      (d_code),
        .takes_arg (d_takes),
        .is_digit  (d_digit),
        .digit     (d_val),
        .is_term   (d_term)
    );

    assign o_busy  = (state == ST_OPCODE) || (state == ST_ARG) || (state == ST_FLUSH);
    assign can_pop = o_busy || (state == ST_IDLE);
    assign tmo_hit = (TIMEOUT_CYC != 0) && o_busy && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
    // A byte landing on the timeout cycle stays in the FIFO for the next line.
    assign o_rx_pop = !rst && !i_rx_empty && can_pop && !tmo_hit;

    always_comb begin
        in_range = 1'b1;
        case (op_code)
            CMD_SEC:  in_range = acc <= ARG_W'(SEC_MAX);
            CMD_MIN:  in_range = acc <= ARG_W'(MIN_MAX);
            CMD_HOUR: in_range = acc <= ARG_W'(HOUR_MAX);
            default:  in_range = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_code     <= CMD_NONE;
            op_arg      <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            pend        <= ERR_UNKNOWN;
            tmo_cnt     <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_code  <= CMD_NONE;
            o_arg       <= '0;
            o_arg_valid <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= ERR_UNKNOWN;
        end else begin
            o_cmd_valid <= 1'b0;
            o_err       <= 1'b0;
            if (o_rx_pop || !o_busy) tmo_cnt <= '0;
            else                     tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                ST_IDLE: if (o_rx_pop) begin
                    acc <= '0;
                    cnt <= '0;
                    if (!i_line_mode) begin
                        if (d_opcode) begin
                            state       <= ST_EXEC;
                            o_cmd_valid <= 1'b1;
                            o_cmd_code  <= d_code;
                            o_arg       <= '0;
                            o_arg_valid <= 1'b0;
                        end else if (!d_term) begin
                            state      <= ST_ERR;
                            o_err      <= 1'b1;
                            o_err_code <= ERR_UNKNOWN;
                        end
                    end else if (d_opcode) begin
                        op_code <= d_code;
                        op_arg  <= d_takes;
                        state   <= ST_OPCODE;
                    end else if (!d_term) begin
                        pend  <= ERR_UNKNOWN;
                        state <= ST_FLUSH;
                    end
                end
                ST_OPCODE, ST_ARG: if (tmo_hit) begin
                    state      <= ST_ERR;
                    o_err      <= 1'b1;
                    o_err_code <= ERR_TIMEOUT;
                end else if (o_rx_pop) begin
                    if (d_term) begin
                        // Range is judged here so the strobe lands during EXEC.
                        state <= ST_EXEC;
                        if (cnt != '0 && !in_range) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_RANGE;
                        end else begin
                            o_cmd_valid <= 1'b1;
                            o_cmd_code  <= op_code;
                            o_arg       <= acc;
                            o_arg_valid <= cnt != '0;
                        end
                    end else if (d_digit && op_arg && cnt < CNT_W'(ARG_DIGITS)) begin
                        acc   <= acc * ARG_W'(10) + ARG_W'(d_val);
                        cnt   <= cnt + CNT_W'(1);
                        state <= ST_ARG;
                    end else begin
                        pend  <= ERR_SYNTAX;
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: if (tmo_hit) begin
                    state      <= ST_ERR;
                    o_err      <= 1'b1;
                    o_err_code <= ERR_TIMEOUT;
                end else if (o_rx_pop && d_term) begin
                    state      <= ST_ERR;
                    o_err      <= 1'b1;
                    o_err_code <= pend;
                end
                ST_EXEC: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: FIFO model feeding the DUT,
// line-level reference parser and a per-cycle strobe checker.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_empty = 1'b1;
    logic       o_rx_pop;
    logic       i_line_mode = 1'b1;
    logic       o_cmd_valid;
    logic [3:0] o_cmd_code;
    logic [6:0] o_arg;
    logic       o_arg_valid;
    logic       o_err;
    logic [1:0] o_err_code;
    logic       o_busy;

    uart_cmd_parser #(
        .DATA_W(8), .ARG_DIGITS(2), .ARG_W(7), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rx_pop(o_rx_pop),
        .i_line_mode(i_line_mode),
        .o_cmd_valid(o_cmd_valid), .o_cmd_code(o_cmd_code),
        .o_arg(o_arg), .o_arg_valid(o_arg_valid),
        .o_err(o_err), .o_err_code(o_err_code), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [3:0] code;
        logic [6:0] arg;
        logic       argv;
        logic       tmo;
        logic       line;
    } ev_t;

    ev_t      exq[$];
    bit [7:0] fifo[$];
    int tests = 0;
    int fails = 0;
    int n_cmd = 0;
    int n_err = 0;
    int last_code, last_arg, last_argv, last_ecode;
    bit pop_q = 0;
    bit prev_pop = 0;
    bit [7:0] prev_byte = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int op_of(input bit [7:0] c);
        case (c)
            "R": return 1;
            "S": return 2;
            "C": return 3;
            "M": return 4;
            "D": return 5;
            "s": return 6;
            "m": return 7;
            "h": return 8;
            default: return 0;
        endcase
    endfunction

    // Reference: judge a whole line (terminator stripped) at once.
    function automatic ev_t model_line(input string s);
        ev_t e;
        int  c, val, lim;
        bit  ok;
        e = '0;
        e.line = 1'b1;
        c = op_of(s[0]);
        if (c == 0) begin
            e.err = 1'b1; e.code = 4'd0;
        end else if (s.len() == 1) begin
            e.code = 4'(c);
        end else begin
            ok  = (c >= 6) && (s.len() - 1 <= 2);
            val = 0;
            for (int i = 1; i < s.len(); i++) begin
                if (s[i] >= "0" && s[i] <= "9") val = val * 10 + (s[i] - "0");
                else ok = 0;
            end
            lim = (c == 8) ? 23 : 59;
            if (!ok) begin
                e.err = 1'b1; e.code = 4'd1;
            end else if (val > lim) begin
                e.err = 1'b1; e.code = 4'd2;
            end else begin
                e.code = 4'(c); e.arg = 7'(val); e.argv = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic send_line(input string s, input bit [7:0] term);
        for (int i = 0; i < s.len(); i++) fifo.push_back(s[i]);
        fifo.push_back(term);
        exq.push_back(model_line(s));
    endtask

    task automatic send_imm(input string s);
        ev_t e;
        for (int i = 0; i < s.len(); i++) begin
            fifo.push_back(s[i]);
            e = '0;
            if (s[i] == 8'h0D || s[i] == 8'h0A) continue;
            if (op_of(s[i]) != 0) e.code = 4'(op_of(s[i]));
            else e.err = 1'b1;
            exq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exq.size() != 0 || fifo.size() != 0 || o_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", int'(n < 300), 1);
        repeat (4) @(negedge clk);
    endtask

    // FIFO: consume the head on a pop cycle, present the new head after the edge.
    always @(posedge clk) begin
        #1;
        if (pop_q && !rst && fifo.size() != 0) fifo.delete(0);
        i_rx_empty = (fifo.size() == 0);
        i_rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    always @(negedge clk) begin
        ev_t e;
        pop_q = o_rx_pop;
        if (!rst) begin
            if (o_rx_pop && i_rx_empty) chk("pop_when_empty", 1, 0);
            if (o_cmd_valid || o_err) begin
                chk("strobe_excl", int'(o_cmd_valid && o_err), 0);
                if (o_cmd_valid) begin
                    n_cmd++;
                    last_code = o_cmd_code; last_arg = o_arg; last_argv = o_arg_valid;
                end
                if (o_err) begin
                    n_err++;
                    last_ecode = o_err_code;
                end
                if (exq.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exq.pop_front();
                    chk("kind_is_err", o_err, e.err);
                    if (e.err) begin
                        chk("err_code", o_err_code, e.code);
                    end else begin
                        chk("cmd_code", o_cmd_code, e.code);
                        chk("arg_valid", o_arg_valid, e.argv);
                        if (e.argv) chk("arg", o_arg, e.arg);
                    end
                    if (e.tmo) chk("tmo_no_pop_before", prev_pop, 0);
                    else chk("latency_pop", prev_pop, 1);
                    if (e.line && !e.tmo)
                        chk("latency_term", int'(prev_byte == 8'h0D || prev_byte == 8'h0A), 1);
                end
            end
        end
        prev_pop  = o_rx_pop && !rst;
        prev_byte = i_rx_data;
    end

    initial begin
        int c0, e0;
        ev_t m;
        bit [6:0] pat;
        ev_t t;

        repeat (3) @(negedge clk);
        chk("rst_pop", o_rx_pop, 0);
        chk("rst_cmd_valid", o_cmd_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_code", o_cmd_code, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Model pins
        m = model_line("s45");
        chk("model_s45", int'({m.err, m.code, m.arg}), int'({1'b0, 4'd6, 7'd45}));
        m = model_line("h24");
        chk("model_h24", int'({m.err, m.code}), int'({1'b1, 4'd2}));
        m = model_line("R5");
        chk("model_R5", int'({m.err, m.code}), int'({1'b1, 4'd1}));

        // 1
        c0 = n_cmd; e0 = n_err;
        @(posedge clk); send_line("s45", 8'h0D);
        wait_idle();
        chk("t1_code", last_code, 6);
        chk("t1_arg", last_arg, 45);
        chk("t1_argv", last_argv, 1);
        chk("t1_cmds", n_cmd - c0, 1);
        chk("t1_errs", n_err - e0, 0);

        // 2
        c0 = n_cmd;
        @(posedge clk); send_line("R", 8'h0A); send_line("m", 8'h0D);
        wait_idle();
        chk("t2_cmds", n_cmd - c0, 2);
        chk("t2_code", last_code, 7);
        chk("t2_argv", last_argv, 0);

        // 3
        c0 = n_cmd; e0 = n_err;
        @(posedge clk); send_line("h24", 8'h0D); send_line("h23", 8'h0D);
        wait_idle();
        chk("t3_errs", n_err - e0, 1);
        chk("t3_cmds", n_cmd - c0, 1);
        chk("t3_code", last_code, 8);
        chk("t3_arg", last_arg, 23);

        // 4
        c0 = n_cmd; e0 = n_err;
        @(posedge clk);
        send_line("x9", 8'h0D); send_line("s123", 8'h0D); send_line("R5", 8'h0D);
        wait_idle();
        chk("t4_errs", n_err - e0, 3);
        chk("t4_cmds", n_cmd - c0, 0);
        chk("t4_last_ecode", last_ecode, 1);
        chk("t4_idle", o_busy, 0);

        // 5
        e0 = n_err;
        @(posedge clk);
        fifo.push_back("s"); fifo.push_back("4");
        t = '0; t.err = 1'b1; t.code = 4'd3; t.tmo = 1'b1; t.line = 1'b1;
        exq.push_back(t);
        repeat (5) @(negedge clk);
        chk("t5_busy", o_busy, 1);
        wait_idle();
        chk("t5_ecode", last_ecode, 3);
        chk("t5_busy_drop", o_busy, 0);
        @(posedge clk); send_line("5", 8'h0D);
        wait_idle();
        chk("t5_late_ecode", last_ecode, 0);
        chk("t5_errs", n_err - e0, 2);

        // 6
        c0 = n_cmd;
        i_line_mode = 1'b0;
        @(posedge clk); send_imm("RS\rC");
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = o_rx_pop;
        end
        chk("t6_pop_pattern", pat, 7'b1010110);
        wait_idle();
        chk("t6_cmds", n_cmd - c0, 3);
        chk("t6_code", last_code, 3);

        // Reset mid-line
        c0 = n_cmd; e0 = n_err;
        i_line_mode = 1'b1;
        @(posedge clk); fifo.push_back("s"); fifo.push_back("4");
        repeat (3) @(negedge clk);
        chk("rr_busy", o_busy, 1);
        #1 rst = 1'b1;
        fifo.delete();
        #1;
        chk("rr_busy0", o_busy, 0);
        chk("rr_pop0", o_rx_pop, 0);
        chk("rr_arg0", o_arg, 0);
        chk("rr_code0", o_cmd_code, 0);
        @(negedge clk); rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("rr_cmds", n_cmd - c0, 0);
        chk("rr_errs", n_err - e0, 0);
        chk("rr_pending", exq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
